// File: rtl/pattern_stream_tx.sv
// Serial pattern transmitter: frames accepted over valid/ready are shifted out on num_o,
// while a golden tracker counts overlapping PAT occurrences actually driven on num_o.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | num_o held at IDLE_BIT, ready for a new frame
// SHIFT  | one data bit per cycle on num_o, DATA_W cycles per frame
// GAP    | GAP_CYC idle cycles after a frame, frame accepted on the last
module pattern_stream_tx #(
    parameter int           DATA_W    = 8,
    parameter int           CNT_W     = 8,
    parameter logic [3:0]   PAT       = 4'b0101,
    parameter bit           MSB_FIRST = 1'b1,
    parameter int           GAP_CYC   = 0,
    parameter logic         IDLE_BIT  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              num_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  exp_cnt_o,
    output logic              of_o
);

    localparam int                 BIT_W    = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [3:0]         GAP_LAST = 4'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  sreg;
    logic [BIT_W-1:0]   bit_cnt;
    logic [3:0]         gap_cnt;
    logic [3:0]         history;

    logic               last_bit;
    logic               last_gap;
    logic               accept;
    logic               match;
    logic               first_bit;
    logic               next_bit;
    logic [DATA_W-1:0]  load_rest;
    logic [DATA_W-1:0]  shift_rest;

    always_comb begin
        last_bit   = (bit_cnt == '0);
        last_gap   = (gap_cnt == '0);
        ready_o    = (state == S_IDLE)
                  || (state == S_SHIFT && last_bit && GAP_CYC == 0)
                  || (state == S_GAP && last_gap);
        accept     = valid_i && ready_o;
        match      = ({history[2:0], num_o} == PAT);
        busy_o     = (state != S_IDLE);
        // sreg holds only the bits still to be sent; the head bit goes straight to num_o
        first_bit  = MSB_FIRST ? data_i[DATA_W-1] : data_i[0];
        next_bit   = MSB_FIRST ? sreg[DATA_W-1] : sreg[0];
        load_rest  = MSB_FIRST ? (data_i << 1) : (data_i >> 1);
        shift_rest = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            num_o     <= IDLE_BIT;
            sreg      <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            history   <= {4{IDLE_BIT}};
            exp_cnt_o <= '0;
            of_o      <= 1'b0;
        end else begin
            history <= {history[2:0], num_o};

            if (match) begin
                if (exp_cnt_o != CNT_MAX)
                    exp_cnt_o <= exp_cnt_o + 1'b1;
                else
                    of_o <= 1'b1;
            end

            if (accept) begin
                state   <= S_SHIFT;
                num_o   <= first_bit;
                sreg    <= load_rest;
                bit_cnt <= BIT_LAST;
            end else begin
                case (state)
                    S_SHIFT: begin
                        if (!last_bit) begin
                            num_o   <= next_bit;
                            sreg    <= shift_rest;
                            bit_cnt <= bit_cnt - 1'b1;
                        end else if (GAP_CYC > 0) begin
                            state   <= S_GAP;
                            num_o   <= IDLE_BIT;
                            gap_cnt <= GAP_LAST;
                        end else begin
                            state <= S_IDLE;
                            num_o <= IDLE_BIT;
                        end
                    end
                    S_GAP: begin
                        num_o <= IDLE_BIT;
                        if (last_gap)
                            state <= S_IDLE;
                        else
                            gap_cnt <= gap_cnt - 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                        num_o <= IDLE_BIT;
                    end
                endcase
            end
        end
    end

endmodule
